// File: rtl/mux_dp_pipe.sv
// N-input datapath select mux with a registered valid/ready output stage.
// A skid register absorbs one extra beat so downstream back-pressure never drops data.
module mux_dp_pipe #(
  parameter  int WIDTH = 32,
  parameter  int N_IN  = 4,
  localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_IN*WIDTH-1:0] din,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      dout,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_err
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  // Out-of-range selects yield zero data; the error flag travels with the beat.
  function automatic logic [WIDTH-1:0] pick_data(input logic [SEL_W-1:0]      s,
                                                 input logic [N_IN*WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < N_IN; k++) begin
      r = (int'(s) == k) ? d[k*WIDTH +: WIDTH] : r;
    end
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  logic             in_ready_q, out_valid_q;
  logic [WIDTH-1:0] m_data_q, s_data_q;
  logic [SEL_W-1:0] m_sel_q, s_sel_q;
  logic             m_err_q, s_err_q;

  logic             accept_s, emit_s;
  logic             m_load_s, m_from_s_s, s_load_s;
  logic [WIDTH-1:0] new_data_s;
  logic             new_err_s;

  assign accept_s   = in_valid & in_ready_q;
  assign emit_s     = out_valid_q & out_ready;
  assign new_data_s = pick_data(sel, din);
  assign new_err_s  = (int'(sel) >= N_IN);

  // Next-state and register load enables for the main/skid pair.
  always_comb begin
    state_d    = state_q;
    m_load_s   = 1'b0;
    m_from_s_s = 1'b0;
    s_load_s   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept_s) begin
          m_load_s = 1'b1;
          state_d  = ONE;
        end else begin
          state_d  = EMPTY;
        end
      end
      ONE: begin
        if (accept_s && emit_s) begin
          m_load_s = 1'b1;
          state_d  = ONE;
        end else if (accept_s) begin
          s_load_s = 1'b1;
          state_d  = FULL;
        end else if (emit_s) begin
          state_d  = EMPTY;
        end else begin
          state_d  = ONE;
        end
      end
      FULL: begin
        if (emit_s) begin
          m_from_s_s = 1'b1;
          state_d    = ONE;
        end else begin
          state_d    = FULL;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State plus handshake flags; in_ready depends only on registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  // Main register: loaded from the input or from the skid register, never otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_q <= '0;
      m_sel_q  <= '0;
      m_err_q  <= 1'b0;
    end else if (m_load_s) begin
      m_data_q <= new_data_s;
      m_sel_q  <= sel;
      m_err_q  <= new_err_s;
    end else if (m_from_s_s) begin
      m_data_q <= s_data_q;
      m_sel_q  <= s_sel_q;
      m_err_q  <= s_err_q;
    end else begin
      m_data_q <= m_data_q;
      m_sel_q  <= m_sel_q;
      m_err_q  <= m_err_q;
    end
  end

  // Skid register: captures the beat accepted while the main register is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_data_q <= '0;
      s_sel_q  <= '0;
      s_err_q  <= 1'b0;
    end else if (s_load_s) begin
      s_data_q <= new_data_s;
      s_sel_q  <= sel;
      s_err_q  <= new_err_s;
    end else begin
      s_data_q <= s_data_q;
      s_sel_q  <= s_sel_q;
      s_err_q  <= s_err_q;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dout      = m_data_q;
  assign out_sel   = m_sel_q;
  assign out_err   = m_err_q;

endmodule

// File: tb/tb_mux_dp_pipe.sv
// Directed + random bench for mux_dp_pipe (N_IN=4 and N_IN=3 instances) with a
// queue scoreboard fed at accept and drained at emit.
module tb_mux_dp_pipe;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  s;
    logic        e;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0, out_err4;
  logic [1:0]  sel4 = 2'd0, out_sel4;
  logic [127:0] din4 = '0;
  logic [31:0] dout4;

  logic        in_valid3 = 1'b0, in_ready3, out_valid3, out_ready3 = 1'b0, out_err3;
  logic [1:0]  sel3 = 2'd0, out_sel3;
  logic [95:0] din3 = '0;
  logic [31:0] dout3;

  mux_dp_pipe #(.WIDTH(32), .N_IN(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .sel(sel4),
    .din(din4), .out_valid(out_valid4), .out_ready(out_ready4), .dout(dout4),
    .out_sel(out_sel4), .out_err(out_err4));

  mux_dp_pipe #(.WIDTH(32), .N_IN(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .sel(sel3),
    .din(din3), .out_valid(out_valid3), .out_ready(out_ready3), .dout(dout3),
    .out_sel(out_sel3), .out_err(out_err3));

  int    pass_cnt = 0;
  int    fail_cnt = 0;
  int    total_cnt = 0;
  int    n_acc4 = 0;
  beat_t q4[$];
  beat_t q3[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t model4(input logic [1:0] s, input logic [127:0] d);
    beat_t b;
    b.d = d[s*32 +: 32];
    b.s = s;
    b.e = 1'b0;
    return b;
  endfunction

  function automatic beat_t model3(input logic [1:0] s, input logic [95:0] d);
    beat_t b;
    b.s = s;
    if (s == 2'd3) begin
      b.d = 32'd0;
      b.e = 1'b1;
    end else begin
      b.d = d[s*32 +: 32];
      b.e = 1'b0;
    end
    return b;
  endfunction

  // One clock: scoreboard bookkeeping from the handshake seen before the edge,
  // then sample again at the following falling edge.
  task automatic tick();
    logic  acc4, emi4, hold4, acc3, emi3;
    beat_t cur4, cur3, b;
    acc4  = in_valid4 && in_ready4;
    emi4  = out_valid4 && out_ready4;
    hold4 = out_valid4 && !out_ready4;
    acc3  = in_valid3 && in_ready3;
    emi3  = out_valid3 && out_ready3;
    cur4  = {dout4, out_sel4, out_err4};
    cur3  = {dout3, out_sel3, out_err3};
    if (emi4) begin
      if (q4.size() == 0) chk("sb4_spurious_valid", out_valid4, 1'b0);
      else begin
        b = q4.pop_front();
        chk("sb4_beat", cur4, b);
      end
    end
    if (emi3) begin
      if (q3.size() == 0) chk("sb3_spurious_valid", out_valid3, 1'b0);
      else begin
        b = q3.pop_front();
        chk("sb3_beat", cur3, b);
      end
    end
    if (acc4) begin
      q4.push_back(model4(sel4, din4));
      n_acc4++;
    end
    if (acc3) q3.push_back(model3(sel3, din3));
    @(posedge clk);
    @(negedge clk);
    if (hold4) chk("stall_stable4", {out_valid4, dout4, out_sel4, out_err4}, {1'b1, cur4});
  endtask

  task automatic drain();
    in_valid4  = 1'b0;
    in_valid3  = 1'b0;
    out_ready4 = 1'b1;
    out_ready3 = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("drain_q4", q4.size(), 0);
    chk("drain_q3", q3.size(), 0);
    chk("drain_valid4", out_valid4, 1'b0);
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_in_ready4", in_ready4, 1'b0);
    chk("rst_out4", {out_valid4, dout4, out_sel4, out_err4}, 36'd0);
    chk("rst_out3", {in_ready3, out_valid3, dout3, out_sel3, out_err3}, 37'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_in_ready_before_edge", in_ready4, 1'b0);
    @(posedge clk);
    #1 chk("rel_in_ready_after_edge", in_ready4, 1'b1);
    @(negedge clk);

    // Select sweep, 1-cycle latency, back-to-back
    din4 = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
    out_ready4 = 1'b1;
    in_valid4  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0]   s;
      logic [127:0] exp_words;
      s = 2'(i);
      sel4 = s;
      tick();
      exp_words = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
      chk("sweep_dout", {out_valid4, dout4, out_sel4}, {1'b1, exp_words[i*32 +: 32], s});
    end
    drain();

    // Back-pressure: A, B fill the stage; C is offered while full and must wait
    out_ready4 = 1'b0;
    in_valid4  = 1'b1;
    sel4 = 2'd0; tick();
    sel4 = 2'd1; tick();
    chk("bp_full_in_ready", in_ready4, 1'b0);
    chk("bp_full_dout", dout4, 32'hAAAA);
    sel4 = 2'd2; tick();
    chk("bp_stall_dout", {in_ready4, dout4}, {1'b0, 32'hAAAA});
    out_ready4 = 1'b1;
    tick();
    chk("bp_after_a", {in_ready4, dout4}, {1'b1, 32'hBBBB});
    tick();
    chk("bp_c_out", dout4, 32'hCCCC);
    drain();

    // Range error on the 3-input instance
    din3 = {32'h3333_2222, 32'h2222_1111, 32'h1111_0000};
    out_ready3 = 1'b1;
    in_valid3  = 1'b1;
    sel3 = 2'd3; tick();
    chk("err_beat", {dout3, out_sel3, out_err3}, {32'd0, 2'd3, 1'b1});
    sel3 = 2'd2; tick();
    chk("err_clear", {dout3, out_sel3, out_err3}, {32'h3333_2222, 2'd2, 1'b0});
    drain();

    // Sustained accept&emit: stage never fills
    out_ready4 = 1'b1;
    in_valid4  = 1'b1;
    for (int i = 0; i < 101; i++) begin
      sel4 = 2'($urandom_range(0, 3));
      din4 = {$urandom, $urandom, $urandom, $urandom};
      tick();
      chk("stream_in_ready", {in_ready4, out_valid4}, 2'b11);
    end
    drain();

    // Random valid/ready with mid-stream garbage on unaccepted cycles
    n_acc4 = 0;
    for (int c = 0; c < 60000 && n_acc4 < 10000; c++) begin
      in_valid4  = 1'($urandom_range(0, 1));
      out_ready4 = 1'($urandom_range(0, 1));
      sel4 = 2'($urandom_range(0, 3));
      din4 = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    chk("rand_beats_accepted", n_acc4, 10000);
    drain();

    // Reset while FULL discards both buffered beats
    out_ready4 = 1'b0;
    in_valid4  = 1'b1;
    sel4 = 2'd1; tick();
    sel4 = 2'd2; tick();
    chk("pre_rst_full", {in_ready4, out_valid4}, 2'b01);
    in_valid4 = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("midrst_out", {in_ready4, out_valid4, dout4}, 34'd0);
    q4.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midrst_rel_before_edge", in_ready4, 1'b0);
    @(posedge clk);
    #1 chk("midrst_rel_after_edge", {in_ready4, out_valid4}, 2'b10);
    @(negedge clk);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
